// File: rtl/w_194_seq_pkg.sv
// Shared encodings for the W_74HC194 command sequencer: command ops, register
// modes, FSM states and small decode helpers.
package w_194_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] mode_of(input op_e op);
    case (op)
      OP_SHR:  return S_SHR;
      OP_SHL:  return S_SHL;
      OP_LOAD: return S_LOAD;
      default: return S_HOLD;
    endcase
  endfunction

  // d[0] feeds right shifts, d[1] feeds left shifts; the unused input stays 0.
  function automatic logic [1:0] serial_of(input op_e op, input logic bit_v);
    case (op)
      OP_SHR:  return {1'b0, bit_v};
      OP_SHL:  return {bit_v, 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/w_194_seq_if.sv
// Command handshake bundle between a command source and the w_194_seq sequencer.
interface w_194_seq_if #(
  parameter int unsigned CNT_W = 3
) ();
  import w_194_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [3:0]       cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/w_194_seq.sv
// Expands one LOAD / SHR / SHL / HOLD command at a time into the per-cycle
// s / d / par stream consumed by a downstream W_74HC194 on the same clock.
module w_194_seq
  import w_194_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic        clk,
  input  logic        mr,
  w_194_seq_if.slave  cmd,
  output logic [1:0]  s,
  output logic [1:0]  d,
  output logic [3:0]  par,
  output logic        busy,
  output logic        done
);

  state_e           state, state_n;
  op_e              op_q, op_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] step, step_n;
  logic [CNT_W-1:0] step_nx;
  logic [1:0]       idx_nx;
  logic [3:0]       data_q, data_n;
  logic [1:0]       s_n, d_n;
  logic [3:0]       par_n;
  logic             busy_n, done_n;
  logic             xfer;

  // A registered done while IDLE only happens in the N=0 acknowledge cycle.
  assign cmd.cmd_ready = mr && (state == IDLE) && !done;
  assign xfer          = cmd.cmd_valid && cmd.cmd_ready;
  assign step_nx       = step + CNT_W'(1);
  assign idx_nx        = 2'(step_nx);

  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    step_n  = step;
    s_n     = S_HOLD;
    d_n     = '0;
    par_n   = par;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          op_n   = cmd.cmd_op;
          cnt_n  = cmd.cmd_cnt;
          data_n = cmd.cmd_data;
          step_n = '0;
          if (cmd.cmd_op == OP_LOAD) begin
            state_n = RUN;
            s_n     = S_LOAD;
            par_n   = cmd.cmd_data;
            busy_n  = 1'b1;
            done_n  = 1'b1;
          end else if (cmd.cmd_cnt == '0) begin
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
            s_n     = mode_of(cmd.cmd_op);
            d_n     = serial_of(cmd.cmd_op, cmd.cmd_data[0]);
            busy_n  = 1'b1;
            done_n  = (cmd.cmd_cnt == CNT_W'(1));
          end
        end
      end
      RUN: begin
        // done marks the step currently on the outputs as the last one.
        if (done) begin
          state_n = IDLE;
          step_n  = '0;
        end else begin
          step_n = step_nx;
          s_n    = s;
          d_n    = serial_of(op_q, data_q[idx_nx]);
          busy_n = 1'b1;
          done_n = (step_nx == (cnt_q - CNT_W'(1)));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!mr) begin
      state  <= IDLE;
      op_q   <= OP_HOLD;
      cnt_q  <= '0;
      data_q <= '0;
      step   <= '0;
      s      <= S_HOLD;
      d      <= '0;
      par    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      cnt_q  <= cnt_n;
      data_q <= data_n;
      step   <= step_n;
      s      <= s_n;
      d      <= d_n;
      par    <= par_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: doc/w_194_seq.md
# w_194_seq

Command sequencer feeding the W_74HC194 universal shift register. Accepts one command at a time over a valid/ready handshake: LOAD, shift-right N, shift-left N, or hold N. Expands each command into the per-cycle mode (`s`), serial-in bits (`d`) and parallel word (`par`) that the register consumes. Sits directly upstream of W_74HC194; its `s`/`d`/`par` outputs wire straight to the register's `s`/`d`/`in`, which shares the same `clk`.

## Interface
- `CNT_W`, default 3: width of the step-count field; maximum N = 2^CNT_W−1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `mr`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE with `mr`=1; a command transfers on a rising edge where `cmd_valid`&`cmd_ready`.
- `cmd_op`  in  2  00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
- `cmd_cnt`  in  CNT_W  number of active cycles N (ignored for LOAD).
- `cmd_data`  in  4  LOAD: parallel word; SHR/SHL: serial bit pattern, bit i used at step i mod 4.
- `s`  out  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 load.
- `d`  out  2  serial inputs: `d[0]` is the right-shift serial in, `d[1]` the left-shift serial in.
- `par`  out  4  parallel word to the register's `in`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse marking the last active cycle of a command.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `s`=00, `d`=00, `busy`=0, `cmd_ready`=1.
  - On transfer, latch op, cnt and data; the step counter clears to 0.
- LOAD: enters RUN for exactly 1 cycle.
  - `s`=11, `par`=cmd_data, `done`=1.
  - Returns to IDLE.
- SHR / SHL / HOLD with N≥1: RUN for N cycles; step i = 0..N−1.
  - `s` = 01 / 10 / 00 respectively.
  - SHR: `d[0]`=data[i mod 4], `d[1]`=0.
  - SHL: `d[1]`=data[i mod 4], `d[0]`=0.
  - HOLD: `d`=00.
  - `done`=1 at step N−1 only; then IDLE.
- N=0 (non-LOAD):
  - Accepted, no RUN entry, `s` stays 00.
  - `done` pulses 1 cycle in the cycle after acceptance.
  - `cmd_ready` is low in that cycle.
- `par` holds the last LOAD value until the next LOAD or reset; `par` is don't-care to the register when `s`≠11.
- All outputs are registered except `cmd_ready` (decode of state & `mr`).
- Step counter is CNT_W bits, counts 0..N−1, never wraps within a command; the data index is the counter's 2 LSBs.

## Timing
- Transfer at edge k → the first active cycle is k..k+1 (outputs valid after edge k). The register acts on the command's first step at edge k+1.
- Command latency: 1 cycle for LOAD; N cycles for the others.
- `cmd_ready` is low throughout RUN and in the N=0 done cycle. It returns high in the cycle after `done`.
- Minimum spacing: one IDLE cycle between consecutive commands (s=00 there).
- `cmd_*` may change freely when not transferring; only values present at the transfer edge are used.
- Reset, sampled at an edge with `mr`=0, from any state including mid-RUN:
  - IDLE, `s`=00, `d`=00, `par`=0000, `busy`=0, `done`=0, step counter 0.
  - An aborted command produces no `done`.
  - `cmd_ready`=0 while `mr`=0, so no command is accepted at a reset edge.
- Power-up state is undefined until the first reset edge.

## Structure
- Package `w_194_pkg`:
  - op encodings OP_HOLD/OP_SHR/OP_SHL/OP_LOAD;
  - mode constants S_HOLD=00, S_SHR=01, S_SHL=10, S_LOAD=11;
  - state enum {IDLE, RUN}.
- Single module, no sub-modules; the step counter is inline.
- Bench top instantiates w_194_seq driving W_74HC194 to check end-to-end register contents.

## Test plan
- Reset: hold `mr`=0 for 2 edges during a SHR N=5 mid-command → next cycle `s`=00, `par`=0000, `busy`=0, no `done`; `cmd_ready`=1 once `mr`=1.
- LOAD 0110 → `s`=11, `par`=0110 for exactly 1 cycle with `done`=1; the downstream register reads 0110.
- After LOAD 0000, SHR N=4 with data 1011 → `d[0]` sequence 1,1,0,1 over steps 0..3; `s`=01 for 4 cycles; `done` on the 4th; register ends at the expected shifted value.
- SHL N=6, data 0101 → `d[1]` sequence 1,0,1,0,1,0 (wrap at step 4); `d[0]`=0 throughout; `busy` high for 6 cycles.
- HOLD N=0 → `done` 1 cycle after acceptance, `s` never leaves 00; HOLD N=7 → `s`=00, `busy`=1 for 7 cycles.
- Back-to-back: `cmd_valid` held high with LOAD 1001 then SHR N=2 → second transfer occurs exactly 1 IDLE cycle after the LOAD `done`; `cmd_ready`=0 during RUN.
